// File: rtl/arbitro_rr_pkg.sv
// Shared constants and helpers for the class-routing arbiter.
// The class of a word is its top CLASS_W bits; CLASS_W = log2(NUM_OUT).
package arbitro_pkg;

  localparam int WORD_SIZE_DEF = 12;
  localparam int NUM_IN_DEF    = 4;
  localparam int NUM_OUT_DEF   = 4;
  localparam int CNT_WIDTH_DEF = 5;

  // Width of an index into n items (at least 1 bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int class_w(input int num_out);
    return idx_w(num_out);
  endfunction

  // Extracts the class field from a word of ws bits (ws <= 64).
  function automatic int unsigned class_of(input logic [63:0] word, input int ws, input int cw);
    logic [63:0] t;
    t = word >> (ws - cw);
    t = t & ((64'd1 << cw) - 64'd1);
    return 32'(t);
  endfunction

endpackage

// File: rtl/arbitro_rr_if.sv
// Bundle between the ingress FIFO bank, the arbiter and the per-class output FIFOs.
// slave = arbiter side, master = the environment driving the FIFO status.
interface arbitro_rr_if #(
  parameter int WORD_SIZE = 12,
  parameter int NUM_IN    = 4,
  parameter int NUM_OUT   = 4,
  parameter int CNT_WIDTH = 5
);
  logic [NUM_IN*WORD_SIZE-1:0]  data_in;
  logic [NUM_IN-1:0]            fifo_empty;
  logic [NUM_OUT-1:0]           fifos_almost_full;
  logic                         fixed_prio;
  logic [NUM_IN-1:0]            pop;
  logic [NUM_OUT-1:0]           push;
  logic [WORD_SIZE-1:0]         data_out_arb;
  logic [NUM_OUT*CNT_WIDTH-1:0] cuenta;
  logic                         idle;

  modport slave (
    input  data_in, fifo_empty, fifos_almost_full, fixed_prio,
    output pop, push, data_out_arb, cuenta, idle
  );

  modport master (
    output data_in, fifo_empty, fifos_almost_full, fixed_prio,
    input  pop, push, data_out_arb, cuenta, idle
  );
endinterface

// File: rtl/arbitro_rr_prio_enc.sv
// Combinational one-hot grant picker: round-robin from ptr, or lowest index when fixed.
module rr_priority_encoder
  import arbitro_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]        req,
  input  logic [idx_w(N)-1:0] ptr,
  input  logic                fixed,
  output logic [N-1:0]        gnt,
  output logic                valid
);
  localparam int PW = idx_w(N);

  logic [PW-1:0] idx;

  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = 0; k < N; k++) begin
      idx = fixed ? PW'(k) : PW'((int'(ptr) + k) % N);
      if (gnt == '0 && req[idx]) gnt[idx] = 1'b1;
    end
  end

  assign valid = |req;

endmodule

// File: rtl/arbitro_rr.sv
// Class-routing arbiter: pops one eligible input FIFO per cycle and pushes the word
// into the output FIFO selected by its class, counting transfers per class.
module arbitro_rr
  import arbitro_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int NUM_IN    = NUM_IN_DEF,
  parameter int NUM_OUT   = NUM_OUT_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic        clk,
  input  logic        reset,
  arbitro_rr_if.slave bus
);
  localparam int CLASS_W = class_w(NUM_OUT);
  localparam int PW      = idx_w(NUM_IN);

  logic [WORD_SIZE-1:0]     word    [NUM_IN];
  logic [CLASS_W-1:0]       cls     [NUM_IN];
  logic [NUM_IN-1:0]        req;
  logic [NUM_IN-1:0]        gnt;
  logic                     gnt_valid;
  logic [PW-1:0]            gnt_idx;
  logic [CLASS_W-1:0]       gnt_cls;

  logic [PW-1:0]            ptr;
  logic [NUM_IN-1:0]        last_gnt;
  logic [NUM_IN-1:0]        pop_q;
  logic [NUM_OUT-1:0]       push_q;
  logic [WORD_SIZE-1:0]     data_q;
  logic                     idle_q;
  logic [CNT_WIDTH-1:0]     cnt     [NUM_OUT];
  logic [NUM_OUT*CNT_WIDTH-1:0] cnt_flat;

  // The input just granted is held off one cycle: its pop is still in flight,
  // so its FIFO head has not advanced yet.
  always_comb begin
    for (int i = 0; i < NUM_IN; i++) begin
      word[i] = bus.data_in[i*WORD_SIZE +: WORD_SIZE];
      cls[i]  = CLASS_W'(class_of(64'(word[i]), WORD_SIZE, CLASS_W));
      req[i]  = !bus.fifo_empty[i] && !bus.fifos_almost_full[cls[i]] && !last_gnt[i];
    end
  end

  rr_priority_encoder #(.N(NUM_IN)) u_enc (
    .req   (req),
    .ptr   (ptr),
    .fixed (bus.fixed_prio),
    .gnt   (gnt),
    .valid (gnt_valid)
  );

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (gnt[i]) gnt_idx = PW'(i);
    end
  end

  assign gnt_cls = cls[gnt_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr      <= '0;
      last_gnt <= '0;
      pop_q    <= '0;
      push_q   <= '0;
      data_q   <= '0;
      idle_q   <= 1'b1;
      for (int c = 0; c < NUM_OUT; c++) cnt[c] <= '0;
    end else begin
      last_gnt <= gnt;
      pop_q    <= gnt;
      idle_q   <= !gnt_valid;
      if (gnt_valid) begin
        push_q       <= NUM_OUT'(1) << gnt_cls;
        data_q       <= word[gnt_idx];
        cnt[gnt_cls] <= cnt[gnt_cls] + CNT_WIDTH'(1);
        // ptr is frozen in fixed-priority mode so round-robin resumes where it left off
        if (!bus.fixed_prio) begin
          if (gnt_idx == PW'(NUM_IN - 1)) ptr <= '0;
          else                            ptr <= gnt_idx + PW'(1);
        end
      end else begin
        push_q <= '0;
      end
    end
  end

  always_comb begin
    cnt_flat = '0;
    for (int c = 0; c < NUM_OUT; c++) cnt_flat[c*CNT_WIDTH +: CNT_WIDTH] = cnt[c];
  end

  assign bus.pop          = pop_q;
  assign bus.push         = push_q;
  assign bus.data_out_arb = data_q;
  assign bus.cuenta       = cnt_flat;
  assign bus.idle         = idle_q;

endmodule

// File: tb/tb_arbitro_rr.sv
// Self-checking bench for arbitro_rr: behavioural model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_arbitro_rr;
  localparam int WS = 12;
  localparam int NI = 4;
  localparam int NO = 4;
  localparam int CW = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  arbitro_rr_if #(.WORD_SIZE(WS), .NUM_IN(NI), .NUM_OUT(NO), .CNT_WIDTH(CW)) bus ();

  arbitro_rr #(.WORD_SIZE(WS), .NUM_IN(NI), .NUM_OUT(NO), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: eligibility and scan order straight from the rules.
  int         m_ptr, m_last, m_g, m_i, m_c;
  int         m_cnt [NO];
  logic [3:0]  e_pop, e_push;
  logic [11:0] e_data;
  logic        e_idle;

  function automatic int word_cls(input int i);
    logic [WS-1:0] w;
    w = bus.data_in[i*WS +: WS];
    return int'(w) >> (WS - 2);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ptr = 0; m_last = -1;
      for (int c = 0; c < NO; c++) m_cnt[c] = 0;
      e_pop = '0; e_push = '0; e_data = '0; e_idle = 1'b1;
    end else begin
      m_g = -1;
      for (int k = 0; k < NI; k++) begin
        m_i = bus.fixed_prio ? k : (m_ptr + k) % NI;
        if (m_g < 0 && !bus.fifo_empty[m_i] && !bus.fifos_almost_full[word_cls(m_i)] && m_i != m_last)
          m_g = m_i;
      end
      if (m_g >= 0) begin
        m_c    = word_cls(m_g);
        e_pop  = 4'(1 << m_g);
        e_push = 4'(1 << m_c);
        e_data = bus.data_in[m_g*WS +: WS];
        m_cnt[m_c] = (m_cnt[m_c] + 1) % (1 << CW);
        if (!bus.fixed_prio) m_ptr = (m_g + 1) % NI;
        e_idle = 1'b0;
      end else begin
        e_pop = '0; e_push = '0; e_idle = 1'b1;
      end
      m_last = m_g;
    end
  end

  function automatic logic [31:0] exp_cuenta();
    logic [31:0] v;
    v = '0;
    for (int c = 0; c < NO; c++) v = v | (32'(m_cnt[c]) << (c * CW));
    return v;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      chk("model_pop",   bus.pop,          e_pop);
      chk("model_push",  bus.push,         e_push);
      chk("model_data",  bus.data_out_arb, e_data);
      chk("model_cnt",   bus.cuenta,       exp_cuenta());
      chk("model_idle",  bus.idle,         e_idle);
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.fifo_empty        = '1;
    bus.fifos_almost_full = '0;
    bus.fixed_prio        = 1'b0;
  endtask

  task automatic set_word(input int i, input int c);
    bus.data_in[i*WS +: WS] = {2'(c), 10'($urandom)};
  endtask

  task automatic do_reset();
    quiet();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic random_cycle();
    bus.data_in           = 48'({$urandom, $urandom});
    bus.fifo_empty        = 4'($urandom) & 4'($urandom);
    bus.fifos_almost_full = 4'($urandom) & 4'($urandom);
    if ($urandom_range(0, 15) == 0) bus.fixed_prio = ~bus.fixed_prio;
  endtask

  int found;

  initial begin
    bus.data_in = '0;
    quiet();
    reset = 1'b1;
    #12 reset = 1'b0;
    @(negedge clk); #1;

    // Async reset mid-cycle after some traffic
    for (int s = 0; s < 20; s++) begin random_cycle(); step(); end
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_pop",   bus.pop,          0);
    chk("rst_push",  bus.push,         0);
    chk("rst_data",  bus.data_out_arb, 0);
    chk("rst_cnt",   bus.cuenta,       0);
    chk("rst_idle",  bus.idle,         1);
    @(negedge clk); #1;
    reset = 1'b0;
    quiet();
    set_word(2, 1);
    bus.fifo_empty = 4'b1011;
    step();
    chk("rst_first_grant", bus.pop, 4'b0100);

    // Round-robin fairness
    do_reset();
    for (int i = 0; i < NI; i++) set_word(i, i);
    bus.fifo_empty = '0;
    for (int s = 0; s < 4; s++) begin
      step();
      chk("rr_pop",  bus.pop,  32'(1 << s));
      chk("rr_push", bus.push, 32'(1 << s));
    end
    chk("rr_cnt", bus.cuenta, 32'h08421);
    quiet();

    // Hold-off: single busy input gets every other cycle
    do_reset();
    set_word(2, 1);
    bus.fifo_empty = 4'b1011;
    for (int s = 1; s <= 6; s++) begin
      step();
      chk("hold_pop", bus.pop, (s % 2 == 1) ? 32'h4 : 32'h0);
    end
    chk("hold_cnt", bus.cuenta, 32'h60);

    // Almost-full bypass and release
    do_reset();
    set_word(0, 3);
    set_word(1, 0);
    bus.fifo_empty        = 4'b1100;
    bus.fifos_almost_full = 4'b1000;
    for (int s = 1; s <= 6; s++) begin
      step();
      chk("af_pop", bus.pop, (s % 2 == 1) ? 32'h2 : 32'h0);
    end
    bus.fifos_almost_full = '0;
    found = 0;
    for (int s = 0; s < 2; s++) begin
      step();
      if (bus.pop[0]) found = 1;
    end
    chk("af_release", found, 1);

    // Fixed priority alternation; ptr frozen while fixed
    do_reset();
    set_word(1, 0);
    bus.fifo_empty = 4'b1101;
    step();
    chk("fx_pre", bus.pop, 4'b0010);
    set_word(0, 0);
    set_word(3, 2);
    bus.fixed_prio = 1'b1;
    bus.fifo_empty = 4'b0110;
    for (int s = 0; s < 4; s++) begin
      step();
      chk("fx_pop", bus.pop, (s % 2 == 0) ? 32'h1 : 32'h8);
    end
    bus.fixed_prio = 1'b0;
    set_word(2, 1);
    bus.fifo_empty = 4'b1001;
    step();
    chk("fx_ptr_held", bus.pop, 4'b0100);

    // Counter wrap, then all outputs almost full
    do_reset();
    set_word(0, 2);
    bus.fifo_empty = 4'b1110;
    for (int s = 0; s < 66; s++) step();
    chk("wrap_cnt", bus.cuenta, 32'h400);
    chk("wrap_model", m_cnt[2], 1);
    bus.fifo_empty        = '0;
    bus.fifos_almost_full = '1;
    for (int s = 0; s < 3; s++) begin
      step();
      chk("allaf_pop",  bus.pop,  0);
      chk("allaf_push", bus.push, 0);
      chk("allaf_idle", bus.idle, 1);
    end

    // Randomized traffic against the model
    do_reset();
    for (int s = 0; s < 3000; s++) begin
      random_cycle();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
